// File: rtl/sad_engine.sv
// rtl/sad_engine.sv - sum-of-absolute-differences engine over two synchronous-read block memories
// Walks addresses 0..N_PIXELS-1, accumulates |a-b| one cycle behind the read, reports on done.
module sad_engine #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int N_PIXELS = 256,
  parameter int SUM_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sad_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] b_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // One extra counter bit so N_PIXELS == 2**ADDR_W is reachable for the terminal test.
  localparam logic [ADDR_W:0] N_CNT = (ADDR_W+1)'(N_PIXELS);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t             state;
  logic [ADDR_W:0]    counter;
  logic [ADDR_W:0]    counter_nx;
  logic [SUM_W-1:0]   acc;
  logic               re_d;
  logic signed [DATA_W:0] diff;
  logic [DATA_W-1:0]  absdiff;

  assign counter_nx = counter + ONE;

  always_comb begin
    diff    = $signed({1'b0, a_data}) - $signed({1'b0, b_data});
    absdiff = diff[DATA_W] ? DATA_W'(-diff) : DATA_W'(diff);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sad_out  <= '0;
      mem_addr <= '0;
      mem_re   <= 1'b0;
      counter  <= '0;
      acc      <= '0;
      re_d     <= 1'b0;
    end else begin
      done <= 1'b0;
      re_d <= mem_re;
      // Read data lags the address by one cycle, so re_d marks a valid pixel pair.
      if (re_d) begin
        acc <= acc + SUM_W'(absdiff);
      end
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            mem_re   <= 1'b1;
            mem_addr <= '0;
            counter  <= '0;
            acc      <= '0;
          end
        end
        RUN: begin
          counter <= counter_nx;
          if (counter_nx >= N_CNT) begin
            state  <= DRAIN;
            mem_re <= 1'b0;
          end else begin
            mem_addr <= counter_nx[ADDR_W-1:0];
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
        end
        DONE: begin
          sad_out <= acc;
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_engine.sv
// tb/tb_sad_engine.sv - randomized scoreboard bench for sad_engine
// Expected results come from a plain array sum of |a-b|; monitors pop and compare on done.
module tb_sad_engine;

  localparam int N  = 256;
  localparam int N2 = 16;

  logic        clk = 1'b0;
  logic        rst_n, start, busy, done, mem_re;
  logic [15:0] sad_out;
  logic [7:0]  mem_addr, a_data, b_data;
  logic        start2, busy2, done2, re2;
  logic [11:0] sad2;
  logic [3:0]  addr2;
  logic [7:0]  a2, b2;

  logic [7:0] mem_a [N];
  logic [7:0] mem_b [N];
  logic [7:0] m2a [N2];
  logic [7:0] m2b [N2];

  typedef struct {int sad; int st_edge;} exp_t;
  exp_t q[$];
  exp_t q2[$];
  exp_t e, e2;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;
  int busy_cnt = 0, re_cnt = 0, addr_exp = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sad_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .sad_out(sad_out), .mem_addr(mem_addr), .mem_re(mem_re),
    .a_data(a_data), .b_data(b_data)
  );

  sad_engine #(.DATA_W(8), .ADDR_W(4), .N_PIXELS(N2), .SUM_W(12)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
    .sad_out(sad2), .mem_addr(addr2), .mem_re(re2),
    .a_data(a2), .b_data(b2)
  );

  // Synchronous-read memories: data appears the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_re) begin
      a_data <= mem_a[mem_addr];
      b_data <= mem_b[mem_addr];
    end
    if (re2) begin
      a2 <= m2a[addr2];
      b2 <= m2b[addr2];
    end
  end

  task automatic check(input string name, input int act, input int expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic int absd(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int ref_main();
    int s = 0;
    for (int k = 0; k < N; k++) s += absd(int'(mem_a[k]), int'(mem_b[k]));
    return s;
  endfunction

  function automatic int ref_small();
    int s = 0;
    for (int k = 0; k < N2; k++) s += absd(int'(m2a[k]), int'(m2b[k]));
    return s;
  endfunction

  task automatic fill(input int mode);
    for (int k = 0; k < N; k++) begin
      case (mode)
        0: begin mem_a[k] = 8'(k);   mem_b[k] = 8'(k);       end
        1: begin mem_a[k] = 8'd255;  mem_b[k] = 8'd0;        end
        2: begin mem_a[k] = 8'd0;    mem_b[k] = 8'd255;      end
        3: begin mem_a[k] = 8'(k);   mem_b[k] = 8'(255 - k); end
        default: begin mem_a[k] = 8'($urandom); mem_b[k] = 8'($urandom); end
      endcase
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic pulse_start(input bit expect_it);
    exp_t x;
    if (expect_it) begin
      x.sad = ref_main();
      x.st_edge = cyc + 1;
      q.push_back(x);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
      re_cnt   = 0;
      addr_exp = 0;
    end else begin
      if (busy) busy_cnt++;
      if (mem_re) begin
        check("mem_addr", int'(mem_addr), addr_exp);
        addr_exp++;
        re_cnt++;
      end
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("sad_out", int'(sad_out), e.sad);
          check("done_latency", cyc - e.st_edge, N + 2);
          check("busy_cycles", busy_cnt, N + 1);
          check("re_cycles", re_cnt, N);
        end
        busy_cnt = 0;
        re_cnt   = 0;
        addr_exp = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && done2) begin
      if (q2.size() == 0) begin
        check("unexpected_done2", 1, 0);
      end else begin
        e2 = q2.pop_front();
        check("sad_out_small", int'(sad2), e2.sad);
        check("done_latency_small", cyc - e2.st_edge, N2 + 2);
      end
    end
  end

  task automatic run_small(input bit rnd);
    exp_t x;
    for (int k = 0; k < N2; k++) begin
      m2a[k] = rnd ? 8'($urandom) : 8'd15;
      m2b[k] = rnd ? 8'($urandom) : 8'd0;
    end
    x.sad = ref_small();
    x.st_edge = cyc + 1;
    q2.push_back(x);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done2) return;
    end
    check("done2_timeout", 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time limit, expected completion");
    $fatal(1);
  end

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    start2 = 1'b0;
    fill(0);
    for (int k = 0; k < N2; k++) begin m2a[k] = 8'd0; m2b[k] = 8'd0; end
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sad_out", int'(sad_out), 0);
    check("rst_mem_re", int'(mem_re), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int m = 0; m < 4; m++) begin
      fill(m);
      pulse_start(1);
      wait_done();
      @(negedge clk);
    end

    for (int r = 0; r < 2; r++) begin
      fill(4);
      pulse_start(1);
      wait_done();
      @(negedge clk);
    end

    // Starts mid-run are ignored; a start while done is showing runs back-to-back.
    fill(4);
    pulse_start(1);
    repeat (8) @(negedge clk);
    pulse_start(0);
    repeat (189) @(negedge clk);
    pulse_start(0);
    wait_done();
    fill(4);
    pulse_start(1);
    wait_done();
    repeat (300) @(negedge clk);

    // Abort mid-run with reset; no done may follow for the aborted run.
    fill(4);
    pulse_start(0);
    repeat (99) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_sad_out", int'(sad_out), 0);
    check("abort_mem_re", int'(mem_re), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(4);
    pulse_start(1);
    wait_done();
    @(negedge clk);

    run_small(0);
    @(negedge clk);
    run_small(1);
    @(negedge clk);

    repeat (20) @(negedge clk);
    check("pending_main", q.size(), 0);
    check("pending_small", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sad_engine.md
Name: sad_engine

Overview:
Sequential controller and datapath that computes the sum of absolute differences (SAD) between two N-pixel blocks held in external synchronous-read memories A and B. It generates read addresses from an internal loop counter and detects the terminal count (counter ≥ N_PIXELS), the same loop-exit test the SAD comparator performs. It accumulates |a−b| and reports the result with a start/busy/done handshake. It sits between the block-fetch logic (which fills A/B and pulses start) and the motion-search logic (which consumes sad_out on done).

Parameters:
DATA_W, 8, pixel width in bits
ADDR_W, 8, memory address width; counter is ADDR_W+1 bits
N_PIXELS, 256, pixels per block; must be ≤ 2**ADDR_W
SUM_W, 16, accumulator/result width; must be ≥ DATA_W+ADDR_W

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse; sad_out valid in this cycle
sad_out  out  SUM_W  final SAD, held until next accepted start
mem_addr  out  ADDR_W  read address to both A and B memories
mem_re  out  1  read enable to both memories
a_data  in  DATA_W  A read data, valid 1 cycle after mem_re
b_data  in  DATA_W  B read data, valid 1 cycle after mem_re

Behaviour:
- Reset (async assert, sync release): state=IDLE; busy=0, done=0, sad_out=0, mem_addr=0, mem_re=0, counter=0, accumulator=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: start=1 -> RUN, clear counter and accumulator; sad_out keeps its old value until DONE.
- RUN: mem_re=1, mem_addr=counter[ADDR_W-1:0], counter increments each cycle. Terminal test is (counter+1) ≥ N_PIXELS, evaluated on the next counter value. When it is true, go to DRAIN. Exactly N_PIXELS RUN cycles, issuing addresses 0..N_PIXELS−1 in order.
- Accumulate: a 1-cycle delayed copy of mem_re (re_d) qualifies the data. When re_d=1, acc <= acc + |a_data − b_data|.
- Absolute difference: compute in DATA_W+1 signed bits, then take magnitude as an unsigned DATA_W value. Zero-extend to SUM_W before adding. Overflow is impossible by the parameter constraint, so there is no saturation.
- DRAIN: mem_re=0; the last read datum is accumulated; -> DONE.
- DONE: sad_out <= acc (registered, so sad_out is visible in the DONE cycle), done=1 for exactly 1 cycle, busy=0; -> IDLE.
- Timing: start sampled high at edge 0. RUN covers edges 1..N, DRAIN is edge N+1, DONE is edge N+2. done is high in the cycle following edge N+2. With the default N=256, done arrives 258 cycles after the start edge.
- busy=1 in RUN and DRAIN only.
- start while busy or in DONE is ignored, not queued. start in the cycle after done (IDLE) is accepted, giving back-to-back operation.
- mem_addr holds its last value when mem_re=0; downstream logic must not depend on it.
- rst_n asserted mid-operation aborts immediately. All outputs return to reset values, including sad_out=0. No done is produced for the aborted run.
- N_PIXELS = 2**ADDR_W: the counter reaches 2**ADDR_W, and its MSB takes part in the terminal test. mem_addr never wraps past N_PIXELS−1.

Test Plan:
1. A[k]=B[k]=k for all k, pulse start -> done exactly 258 cycles after the start edge, sad_out=0, busy high for 257 cycles.
2. A=255 and B=0 everywhere -> sad_out=65280 (0xFF00), no overflow; swap A and B -> 65280 again, checking abs in both directions.
3. A[k]=k, B[k]=255−k -> sad_out=32768. Also check that mem_addr runs 0..255 in order with mem_re high for exactly 256 cycles.
4. Pulse start again at cycles 10 and 200 of a run -> ignored: one done only, result unchanged. Pulse start in the cycle after done -> a second run completes 258 cycles later with the correct value.
5. Drop rst_n at RUN cycle 100 -> busy, done and sad_out go to 0 asynchronously and mem_re goes to 0. After release, a new start gives a correct result with no residual accumulation.
6. Parameter build N_PIXELS=16, ADDR_W=4, SUM_W=12, with A=15 and B=0 -> sad_out=240, done 18 cycles after start.
